mem_ctrl: RTL and testbench

// Responder side of the byte-serial memory protocol used by the IF and MEM stages. Owns the single 8-bit synchronous RAM port.

---
 rtl/mem_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder side of the byte-serial memory protocol.
// Owns the single 8-bit synchronous RAM port and arbitrates between
// instruction fetch (IF) and load/store (MEM) requests. It sequences
// per-byte RAM accesses and returns little-endian words. Every output
// is driven straight from a register.
//
// Handshake: a requester raises *_req_i and keeps it high (MEM also keeps
// every qualifier stable) until it sees its one-cycle *_done_o pulse. The
// request is accepted only in IDLE. The DONE cycle that follows every
// completion ignores requests, so a request still held there is not taken
// twice. mem_req_i wins over if_req_i when both are pending. An IF read is
// aborted when if_req_i drops. A MEM access always runs to completion.
module mem_ctrl #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;        // edges elapsed since accept
  logic [2:0]        nbytes_q, nbytes_d;  // 1, 2 or 4
  logic              is_if_q, is_if_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;        // read assembly buffer
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;
  logic              busy_q, busy_d;

  logic [2:0] k_next;      // index of the edge being evaluated
  logic [2:0] cap_idx;     // byte captured on this edge (reads lag by two)
  logic [2:0] mem_nbytes;
  logic       unused_bits;

  assign k_next  = cnt_q + 3'd1;
  assign cap_idx = k_next - 3'd2;

  // Address bits above the RAM width are dropped on purpose.
  assign unused_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W], cap_idx[2]};

  // Decode the MEM byte count; any unsupported length means a full word.
  always_comb begin
    mem_nbytes = 3'd4;
    case (mem_len_i)
      3'd1:    mem_nbytes = 3'd1;
      3'd2:    mem_nbytes = 3'd2;
      default: mem_nbytes = 3'd4;
    endcase
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    is_if_d     = is_if_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data_q;
    if_done_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          base_d   = mem_addr_i[ADDR_W-1:0];
          ram_a_d  = mem_addr_i[ADDR_W-1:0];
          nbytes_d = mem_nbytes;
          is_if_d  = 1'b0;
          wdata_d  = mem_wdata_i;
          cnt_d    = 3'd0;
          buf_d    = 32'd0;
          if (mem_we_i) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata_i[7:0];
            state_d    = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end else if (if_req_i) begin
          base_d   = if_addr_i[ADDR_W-1:0];
          ram_a_d  = if_addr_i[ADDR_W-1:0];
          nbytes_d = 3'd4;
          is_if_d  = 1'b1;
          cnt_d    = 3'd0;
          buf_d    = 32'd0;
          state_d  = ST_READ;
        end
      end

      ST_READ: begin
        if (is_if_q && !if_req_i) begin
          // Fetch flushed by the pipeline: drop the partial word.
          state_d = ST_IDLE;
        end else begin
          cnt_d = k_next;
          if (k_next < nbytes_q) begin
            ram_a_d = base_q + ADDR_W'(k_next);
          end
          if (k_next >= 3'd2) begin
            buf_d[{cap_idx[1:0], 3'b000} +: 8] = ram_din_i;
          end
          if (k_next == nbytes_q + 3'd1) begin
            if (is_if_q) begin
              if_data_d = buf_d;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = buf_d;
              mem_done_d  = 1'b1;
            end
            state_d = ST_DONE;
          end
        end
      end

      ST_WRITE: begin
        if (k_next < nbytes_q) begin
          cnt_d      = k_next;
          ram_a_d    = base_q + ADDR_W'(k_next);
          ram_dout_d = wdata_q[{k_next[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end else begin
          mem_done_d = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      is_if_q     <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= 32'd0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= 32'd0;
      mem_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      is_if_q     <= is_if_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_data_q   <= if_data_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      busy_q      <= busy_d;
    end
  end

  assign if_data_o   = if_data_q;
  assign if_done_o   = if_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_done_o  = mem_done_q;
  assign busy_o      = busy_q;
  assign ram_a_o     = ram_a_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_wr_o    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a
// byte-array memory model that works on whole accesses.
module tb_mem_ctrl;
  localparam int          ADDR_W = 18;
  localparam int          RAM_SZ = 1 << ADDR_W;
  localparam logic [31:0] MASK   = 32'(RAM_SZ - 1);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              if_req = 1'b0;
  logic [31:0]       if_addr = 32'd0;
  logic [31:0]       if_data_o;
  logic              if_done_o;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [2:0]        mem_len = 3'd0;
  logic [31:0]       mem_addr = 32'd0;
  logic [31:0]       mem_wdata = 32'd0;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;
  logic              busy_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic [7:0]        ram_dout_o;
  logic              ram_wr_o;
  logic [7:0]        ram_din = 8'd0;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .busy_o(busy_o), .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din)
  );

  // ---------------- environment RAM (synchronous, byte wide) ----------------
  logic [7:0] ram [RAM_SZ];
  int         wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_wr_o) begin
      ram[ram_a_o] <= ram_dout_o;
      wr_cnt       <= wr_cnt + 1;
    end
    ram_din <= ram[ram_a_o];
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]  ref_mem [RAM_SZ];
  logic [31:0] exp_q[$];
  logic [31:0] last_if = 32'd0;
  logic [31:0] last_mem = 32'd0;
  int          tests = 0;
  int          fails = 0;

  function automatic int nbytes_of(input logic [2:0] len);
    return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) w = w | (32'(ref_mem[(addr + 32'(i)) & MASK]) << (8 * i));
    return w;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[(addr + 32'(i)) & MASK] = 8'(wd >> (8 * i));
  endtask

  task automatic preload(input logic [31:0] addr, input logic [7:0] d);
    ram[addr & MASK]     = d;
    ref_mem[addr & MASK] = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at the accept edge; counts edges until the wanted done pulse.
  task automatic wait_done(input bit want_if, output int lat, output bit busy_all,
                           output bit other_pulse);
    bit got;
    lat = 0; busy_all = 1'b1; other_pulse = 1'b0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk);
      lat++;
      #1;
      if (want_if ? if_done_o : mem_done_o) got = 1'b1;
      else if (!busy_o) busy_all = 1'b0;
      if (want_if ? mem_done_o : if_done_o) other_pulse = 1'b1;
    end
    if (!got) lat = -1;
  endtask

  task automatic do_txn(input string tag, input bit is_if, input bit we, input logic [2:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n, lat, w0;
    bit busy_all, other;
    logic [31:0] exp;
    bit store;
    store = we && !is_if;
    n = is_if ? 4 : nbytes_of(len);
    if (!store) exp_q.push_back(model_read(addr, n));
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end
    w0 = wr_cnt;
    @(posedge clk);
    wait_done(is_if, lat, busy_all, other);
    check({tag, "_lat"}, 32'(lat), store ? 32'(n) : 32'(n + 1));
    check({tag, "_busy"}, 32'(busy_all), 32'd1);
    check({tag, "_xpulse"}, 32'(other), 32'd0);
    if (is_if) begin
      exp = exp_q.pop_front();
      check({tag, "_ifdata"}, if_data_o, exp);
      check({tag, "_memhold"}, mem_rdata_o, last_mem);
      last_if = exp;
    end else if (!we) begin
      exp = exp_q.pop_front();
      check({tag, "_rdata"}, mem_rdata_o, exp);
      check({tag, "_ifhold"}, if_data_o, last_if);
      last_mem = exp;
    end else begin
      check({tag, "_memhold"}, mem_rdata_o, last_mem);
      check({tag, "_ifhold"}, if_data_o, last_if);
    end
    // Request still held through the DONE cycle: must not be re-accepted.
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_pulse1"}, {30'd0, if_done_o, mem_done_o}, 32'd0);
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0;
    if (store) begin
      model_write(addr, n, wdata);
      check({tag, "_wrcnt"}, 32'(wr_cnt - w0), 32'(n));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat, n_diff, w0;
    bit busy_all, other, saw_done;
    logic [31:0] exp_m, exp_f, a, wd;
    logic [2:0] len;
    int op;

    for (int i = 0; i < RAM_SZ; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {if_data_o ^ mem_rdata_o, 31'd0, busy_o},
          33'd0 == 33'd0 ? 32'd0 : 32'd1);
    check("rst_data", if_data_o | mem_rdata_o, 32'd0);
    check("rst_ctrl", {26'd0, if_done_o, mem_done_o, busy_o, ram_wr_o, 2'b00}, 32'd0);
    check("rst_ram", {6'd0, ram_a_o, ram_dout_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch at 0x100 -> 0x00000513, done 5 cycles after accept.
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    do_txn("fetch100", 1'b1, 1'b0, 3'd4, 32'h100, 32'd0);
    check("fetch100_const", if_data_o, 32'h00000513);

    // Simultaneous IF and MEM: MEM wins, fetch follows after DONE.
    exp_m = model_read(32'h200, 4);
    exp_f = model_read(32'h140, 4);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd4; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h140;
    @(posedge clk);
    wait_done(1'b0, lat, busy_all, other);
    check("arb_mem_lat", 32'(lat), 32'd5);
    check("arb_mem_busy", 32'(busy_all), 32'd1);
    check("arb_no_if_first", 32'(other), 32'd0);
    check("arb_mem_data", mem_rdata_o, exp_m);
    last_mem = exp_m;
    @(negedge clk);
    mem_req = 1'b0;
    wait_done(1'b1, lat, busy_all, other);
    check("arb_if_lat", 32'(lat), 32'd7);
    check("arb_if_data", if_data_o, exp_f);
    last_if = exp_f;
    @(negedge clk);
    check("arb_done_busy", {31'd0, busy_o}, 32'd1);
    if_req = 1'b0;
    @(posedge clk);
    #1;
    check("arb_idle", {31'd0, busy_o}, 32'd0);

    // Store one byte at the top of RAM.
    do_txn("st_top", 1'b0, 1'b1, 3'd1, 32'h0003FFFF, 32'hAABBCCDD);
    check("st_top_byte", {24'd0, ram[ADDR_W'(32'h3FFFF)]}, 32'h000000DD);

    // Load two bytes across the wrap point.
    preload(32'h3FFFF, 8'h34); preload(32'h0, 8'h12);
    do_txn("ld_wrap", 1'b0, 1'b0, 3'd2, 32'h0003FFFF, 32'd0);
    check("ld_wrap_const", mem_rdata_o, 32'h00001234);

    // Fetch aborted two cycles in.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h180;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    if_req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle", {31'd0, busy_o}, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (if_done_o) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_data_hold", if_data_o, last_if);
    do_txn("after_abort", 1'b1, 1'b0, 3'd4, 32'h180, 32'd0);

    // Reset pulled during the second byte of a store.
    a = 32'h0000_0300; wd = 32'h8765_4321;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd4; mem_addr = a; mem_wdata = wd;
    w0 = wr_cnt;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rstw_writing", {31'd0, ram_wr_o}, 32'd1);
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    check("rstw_wr_async", {31'd0, ram_wr_o}, 32'd0);
    check("rstw_busy_async", {31'd0, busy_o}, 32'd0);
    check("rstw_data_clr", if_data_o | mem_rdata_o, 32'd0);
    model_write(a, 1, wd);
    last_if = 32'd0; last_mem = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw_wrcnt", 32'(wr_cnt - w0), 32'd1);
    do_txn("after_rst", 1'b0, 1'b0, 3'd4, a, 32'd0);

    // Randomized mix of fetches, loads and stores.
    for (int t = 0; t < 40; t++) begin
      op  = $urandom_range(0, 2);
      len = 3'($urandom_range(0, 7));
      wd  = $urandom;
      a   = $urandom;
      case ($urandom_range(0, 2))
        0:       a[17:0] = 18'($urandom_range(0, 63));
        1:       a[17:0] = 18'h3FFF8 + 18'($urandom_range(0, 7));
        default: a = a;
      endcase
      do_txn($sformatf("rnd%0d", t), op == 0, op == 2, len, a, wd);
    end

    // Whole-RAM image must match the model: catches stray writes.
    n_diff = 0;
    for (int i = 0; i < RAM_SZ; i++) if (ram[i] !== ref_mem[i]) n_diff++;
    check("ram_image", 32'(n_diff), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
